// File: rtl/cpu_clint_pkg.sv
// cpu_clint shared definitions: register offsets, reset values, helpers.
// Optional prescaler build: define CLINT_PRESCALER_EN.
package cpu_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } sel_e;

    function automatic logic [31:0] wstrb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_clint_if.sv
// cpu_clint data-bus port: valid/ready request, single-cycle response.
// Optional prescaler build: define CLINT_PRESCALER_EN.
interface cpu_clint_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/cpu_clint_mtime.sv
// cpu_clint 64-bit mtime counter with per-half byte-write port.
// Tick divider present only when CLINT_PRESCALER_EN is defined.
module cpu_clint_mtime
    import cpu_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtime_next
);
    logic write;
    logic tick;

    assign write = we_lo | we_hi;

`ifdef CLINT_PRESCALER_EN
    localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DIV_W-1:0] div_q;

    assign tick = (div_q == DIV_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (write || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end
`else
    // Every cycle is a tick; a non-positive PRESCALE freezes the timer.
    assign tick = (PRESCALE > 0);
`endif

    // A software write wins over the tick and drops that increment.
    always_comb begin
        mtime_next = mtime;
        if (write) begin
            if (we_lo) mtime_next[31:0]  = wstrb_merge(mtime[31:0], wdata, wstrb);
            if (we_hi) mtime_next[63:32] = wstrb_merge(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else begin
            mtime <= mtime_next;
        end
    end

endmodule

// File: rtl/cpu_clint.sv
// cpu_clint top: address decode, wstrb merge, response and compare registers.
// Optional prescaler build: define CLINT_PRESCALER_EN.
module cpu_clint
    import cpu_clint_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 16,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_clint_if.slave  bus,
    output logic        mti_pending,
    output logic        msi_pending
);
    sel_e        sel;
    logic        acc;
    logic        wr;
    logic        msip_q;
    logic [63:0] cmp_q;
    logic [63:0] cmp_next;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [XLEN-1:0] rd;

    assign bus.req_ready = 1'b1;
    assign acc           = bus.req_valid & bus.req_ready;
    assign wr            = acc & bus.req_we;
    assign msi_pending   = msip_q;

    always_comb begin
        sel = SEL_NONE;
        if (bus.req_addr[1:0] == 2'b00) begin
            unique case (1'b1)
                (bus.req_addr == ADDR_W'(CLINT_MSIP)):        sel = SEL_MSIP;
                (bus.req_addr == ADDR_W'(CLINT_MTIMECMP_LO)): sel = SEL_CMP_LO;
                (bus.req_addr == ADDR_W'(CLINT_MTIMECMP_HI)): sel = SEL_CMP_HI;
                (bus.req_addr == ADDR_W'(CLINT_MTIME_LO)):    sel = SEL_TIME_LO;
                (bus.req_addr == ADDR_W'(CLINT_MTIME_HI)):    sel = SEL_TIME_HI;
                default:                                      sel = SEL_NONE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (sel)
            SEL_MSIP:    rd = {{(XLEN-1){1'b0}}, msip_q};
            SEL_CMP_LO:  rd = cmp_q[31:0];
            SEL_CMP_HI:  rd = cmp_q[63:32];
            SEL_TIME_LO: rd = mtime[31:0];
            SEL_TIME_HI: rd = mtime[63:32];
            default:     rd = '0;
        endcase
    end

    always_comb begin
        cmp_next = cmp_q;
        if (wr && sel == SEL_CMP_LO)
            cmp_next[31:0] = wstrb_merge(cmp_q[31:0], bus.req_wdata, bus.req_wstrb);
        if (wr && sel == SEL_CMP_HI)
            cmp_next[63:32] = wstrb_merge(cmp_q[63:32], bus.req_wdata, bus.req_wstrb);
    end

    cpu_clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_lo      (wr && sel == SEL_TIME_LO),
        .we_hi      (wr && sel == SEL_TIME_HI),
        .wdata      (bus.req_wdata),
        .wstrb      (bus.req_wstrb),
        .mtime      (mtime),
        .mtime_next (mtime_next)
    );

    // Compare on next-state values so pending lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q       <= MTIMECMP_RESET;
            msip_q      <= 1'b0;
            mti_pending <= 1'b0;
        end else begin
            cmp_q       <= cmp_next;
            mti_pending <= (mtime_next >= cmp_next);
            if (wr && sel == SEL_MSIP && bus.req_wstrb[0])
                msip_q <= bus.req_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= acc;
            bus.resp_rdata <= (acc && !bus.req_we) ? rd : '0;
            bus.resp_err   <= acc && (sel == SEL_NONE);
        end
    end

endmodule
